nibble_add_seq: RTL and testbench



---
 rtl/nibble_add_seq.sv | 115 +++++++++++
 tb/tb_nibble_add_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor built around one shared 4-bit carry-lookahead slice.
// Operands are walked one nibble per clock, LSB first, with the carry registered between nibbles.
module nibble_add_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             op_busy,
    output logic             op_done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    // state | meaning
    // IDLE  | waiting for op_start; result/flags hold the last completed operation
    // RUN   | one nibble per cycle through the lookahead slice, idx = current nibble
    // DONE  | single-cycle op_done pulse, then back to IDLE

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             cy;
    logic [IDX_W-1:0] idx;

    logic [3:0] nib_a, nib_b, g, p, sum;
    logic       c1, c2, c3, co;
    logic       last;

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (op_start) state_next = RUN;
            RUN:     if (last)     state_next = DONE;
            DONE:                  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    assign op_busy = (state == RUN);
    assign op_done = (state == DONE);

    // Carry-lookahead slice: c1..co all derived from g/p and the registered carry-in.
    always_comb begin
        nib_a = a_reg[idx*4 +: 4];
        nib_b = b_reg[idx*4 +: 4];
        g     = nib_a & nib_b;
        p     = nib_a ^ nib_b;
        c1    = g[0] | (p[0] & cy);
        c2    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cy);
        c3    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cy);
        co    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (&p & cy);
        sum   = p ^ {c3, c2, c1, cy};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            cy        <= 1'b0;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_start) begin
                        a_reg     <= op_a;
                        b_reg     <= op_sub ? ~op_b : op_b;
                        cy        <= op_sub;
                        idx       <= '0;
                        result    <= '0;
                        carry_out <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                RUN: begin
                    result[idx*4 +: 4] <= sum;
                    cy                 <= co;
                    // idx returns to 0 on the last nibble so it never exceeds N-1 for non-power-of-2 N.
                    if (last) begin
                        idx       <= '0;
                        carry_out <= co;
                        overflow  <= c3 ^ co;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (WIDTH=32): vector table plus hand-written
// sequences for start-while-busy, back-to-back start and mid-operation reset.
module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_start;
    logic        op_sub;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_busy;
    logic        op_done;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_add_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_start  (op_start),
        .op_sub    (op_sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_busy   (op_busy),
        .op_done   (op_done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp_res;
        logic        exp_co;
        logic        exp_ov;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts an operation, then watches up to 30 cycles. Cycle c=1 is the first cycle after
    // the accepting edge. If inject_at>0, op_start is pulsed (A=B=0) in that cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input int inject_at, output int busy_n, output int done_at,
                         output logic [31:0] first_res);
        @(negedge clk);
        op_a = a; op_b = b; op_sub = sub; op_start = 1'b1;
        busy_n = 0; done_at = 0; first_res = 'x;
        for (int c = 1; c <= 30 && done_at == 0; c++) begin
            @(negedge clk);
            op_start = (c == inject_at);
            if (c == inject_at) begin
                op_a = '0; op_b = '0; op_sub = 1'b0;
            end
            if (c == 1) first_res = result;
            if (op_busy) busy_n++;
            if (op_done) done_at = c;
        end
        op_start = 1'b0;
    endtask

    int          busy_n, done_at;
    logic [31:0] first_res;
    int          seen_done;

    initial begin
        vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[9] = '{32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0, 1'b0};

        reset = 1'b1; op_start = 1'b0; op_sub = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   32'(op_busy),   32'd0);
        check("reset_done",   32'(op_done),   32'd0);
        check("reset_result", result,         32'd0);
        check("reset_co",     32'(carry_out), 32'd0);
        check("reset_ov",     32'(overflow),  32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub, 0, busy_n, done_at, first_res);
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'd8);
            check($sformatf("v%0d_done_cycle", i),  32'(done_at), 32'd9);
            check($sformatf("v%0d_res_cleared", i), first_res, 32'd0);
            check($sformatf("v%0d_result", i),      result, vecs[i].exp_res);
            check($sformatf("v%0d_carry_out", i),   32'(carry_out), 32'(vecs[i].exp_co));
            check($sformatf("v%0d_overflow", i),    32'(overflow),  32'(vecs[i].exp_ov));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 32'(op_done), 32'd0);
            check($sformatf("v%0d_res_held", i),   result, vecs[i].exp_res);
        end

        // Start while busy is ignored; then a start in the cycle after DONE is accepted.
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 3, busy_n, done_at, first_res);
        check("busy_start_done_cycle", 32'(done_at), 32'd9);
        check("busy_start_result",     result, 32'h2345_6789);
        do_op(32'h0000_0010, 32'h0000_0020, 1'b0, 0, busy_n, done_at, first_res);
        check("b2b_done_cycle", 32'(done_at), 32'd9);
        check("b2b_busy",       32'(busy_n),  32'd8);
        check("b2b_result",     result, 32'h0000_0030);

        // Reset in cycle T+4 of a run.
        @(negedge clk);
        op_a = 32'h1234_5678; op_b = 32'h1111_1111; op_sub = 1'b0; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy",   32'(op_busy),   32'd0);
        check("rst_mid_done",   32'(op_done),   32'd0);
        check("rst_mid_result", result,         32'd0);
        check("rst_mid_co",     32'(carry_out), 32'd0);
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (op_done || op_busy) seen_done++;
        end
        check("rst_mid_no_activity", 32'(seen_done), 32'd0);
        do_op(32'd3, 32'd4, 1'b0, 0, busy_n, done_at, first_res);
        check("post_rst_done_cycle", 32'(done_at), 32'd9);
        check("post_rst_result",     result, 32'h0000_0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
